mips_multicycle_ctrl: RTL



---
 rtl/mips_mc_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 25 ++
 rtl/mips_multicycle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// The JUMP state only exists when MC_CTRL_JUMP_EN is defined.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_BEQ_EX,
    S_ADDI_EX,
    S_ADDI_WB
`ifdef MC_CTRL_JUMP_EN
    , S_JUMP
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to an ALU operation; unknown functs are
// flagged so DECODE can turn the instruction into a no-op.
module alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_XOR:  alu_control = ALU_XOR;
      FN_SLT:  alu_control = ALU_SLT;
      FN_MUL:  alu_control = ALU_MUL;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing MIPS instructions through the shared datapath.
// Define MC_CTRL_JUMP_EN to support the j instruction.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  state_t     state, state_next;
  logic       pc_write;
  logic       branch;
  logic [2:0] funct_alu;
  logic       funct_illegal;

  alu_decoder u_alu_decoder (
    .funct         (funct),
    .alu_control   (funct_alu),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Branch is only taken when BEQ_EX sees the ALU subtraction yield zero.
  assign pc_en = pc_write | (branch & zero_flag);

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    branch        = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_control   = ALU_ADD;
    illegal_instr = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_DECODE;
      end

      // Branch target is precomputed here so BEQ_EX can select ALUOut.
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_RTYPE: begin
            if (funct_illegal) begin
              illegal_instr = 1'b1;
              state_next    = S_FETCH;
            end else begin
              state_next = S_RTYPE_EX;
            end
          end
          OP_BEQ:  state_next = S_BEQ_EX;
          OP_ADDI: state_next = S_ADDI_EX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:    state_next = S_JUMP;
`endif
          default: begin
            illegal_instr = 1'b1;
            state_next    = S_FETCH;
          end
        endcase
      end

      S_MEM_ADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        iord       = 1'b1;
        state_next = S_MEM_WB;
      end

      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_RTYPE_EX: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_next  = S_RTYPE_WB;
      end

      S_RTYPE_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_BEQ_EX: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = PCSRC_ALUOUT;
        state_next  = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
`endif

      default: state_next = S_IDLE;
    endcase
  end

endmodule
